// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the countdown timer controller.
//   state_t   : controller states IDLE..DONE (3-bit encoding 0..4)
//   field_t   : edit field codes FLD_SEC / FLD_MIN / FLD_HR
//   *_W       : output widths of the seconds / minutes / hours registers
//   *_MAX     : wrap limits of each time field
//   inc_wrap  : increment-with-wrap helper shared by all three fields
// -----------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FLD_SEC = 2'd0,
    FLD_MIN = 2'd1,
    FLD_HR  = 2'd2
  } field_t;

  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned HR_W  = 7;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0]  HR_MAX  = 7'd99;

  // Operates at the widest field width; narrower fields are zero-extended
  // on the way in and truncated on the way out.
  function automatic logic [HR_W-1:0] inc_wrap(input logic [HR_W-1:0] v,
                                               input logic [HR_W-1:0] max);
    return (v >= max) ? '0 : v + HR_W'(1);
  endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// -----------------------------------------------------------------------------
// timer_tick_gen
// Prescaler producing a one-cycle tick every FREQUENCY enabled cycles.
//   FREQUENCY : enabled i_clk cycles per tick
//   i_clk     : system clock
//   i_rst     : synchronous active-high reset
//   i_en      : count enable
//   i_clr     : synchronous clear of the partial count (wins over i_en)
//   o_tick    : high while the count sits at FREQUENCY-1 and i_en is high
// -----------------------------------------------------------------------------
module timer_tick_gen #(
  parameter int unsigned FREQUENCY = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (FREQUENCY > 1) ? $clog2(FREQUENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(FREQUENCY - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  // Independent of i_clr: the controller derives i_clr from its next state,
  // which itself depends on the tick.
  assign w_tick = i_en && (r_cnt == LAST);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
// HH:MM:SS countdown timer controller driven by one-cycle command pulses.
// Optional macro TIMER_CTRL_RELOAD_EN adds a preset register that is captured
// on RUN entry from IDLE/SET and restored into the time when DONE is left.
//   FREQUENCY    : i_clk cycles per second
//   ALARM_SECS   : seconds spent in DONE before returning to IDLE
//   i_clk        : system clock
//   i_rst        : synchronous active-high reset
//   i_start_stop : start / pause / resume / acknowledge alarm
//   i_sel        : enter SET or advance the edit field
//   i_inc        : increment the selected field in SET
//   i_clear      : abort to IDLE and zero the time
//   o_seconds    : seconds 0..59
//   o_minutes    : minutes 0..59
//   o_hours      : hours 0..99
//   o_state      : state encoding (IDLE=0 SET=1 RUN=2 PAUSE=3 DONE=4)
//   o_field      : edit field (0 outside SET)
//   o_running    : high in RUN
//   o_alarm      : high in DONE
// Command priority: i_clear > i_start_stop > i_sel > i_inc.
// -----------------------------------------------------------------------------
module timer_ctrl
  import timer_pkg::*;
#(
  parameter logic [31:0] FREQUENCY  = 32'd50_000_000,
  parameter logic [7:0]  ALARM_SECS = 8'd10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start_stop,
  input  logic             i_sel,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [SEC_W-1:0] o_seconds,
  output logic [MIN_W-1:0] o_minutes,
  output logic [HR_W-1:0]  o_hours,
  output logic [2:0]       o_state,
  output logic [1:0]       o_field,
  output logic             o_running,
  output logic             o_alarm
);

  state_t           r_state, w_next_state;
  field_t           r_field, w_field;
  logic [SEC_W-1:0] r_sec, w_sec;
  logic [MIN_W-1:0] r_min, w_min;
  logic [HR_W-1:0]  r_hr, w_hr;
  logic [7:0]       r_alarm_cnt, w_alarm_cnt;
  logic             r_running, r_alarm;

  logic             w_tick;
  logic             w_presc_en;
  logic             w_presc_clr;
  logic             w_nonzero;
  logic             w_last_sec;
  logic             w_alarm_last;

  logic [SEC_W-1:0] w_pre_sec;
  logic [MIN_W-1:0] w_pre_min;
  logic [HR_W-1:0]  w_pre_hr;

  // ---------------------------------------------------------------------------
  // 1 Hz timebase: runs in RUN and DONE, restarts on every state change.
  // ---------------------------------------------------------------------------
  assign w_presc_en  = (r_state == RUN) || (r_state == DONE);
  assign w_presc_clr = i_clear || (w_next_state != r_state);

  timer_tick_gen #(
    .FREQUENCY (FREQUENCY)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_presc_en),
    .i_clr  (w_presc_clr),
    .o_tick (w_tick)
  );

  assign w_nonzero    = (r_sec != '0) || (r_min != '0) || (r_hr != '0);
  assign w_last_sec   = (r_sec == SEC_W'(1)) && (r_min == '0) && (r_hr == '0);
  assign w_alarm_last = ({1'b0, r_alarm_cnt} + 9'd1) >= {1'b0, ALARM_SECS};

  // ---------------------------------------------------------------------------
  // Preset register (optional)
  // ---------------------------------------------------------------------------
`ifdef TIMER_CTRL_RELOAD_EN
  logic             w_load_preset;
  logic [SEC_W-1:0] r_pre_sec;
  logic [MIN_W-1:0] r_pre_min;
  logic [HR_W-1:0]  r_pre_hr;

  assign w_load_preset = !i_clear && (w_next_state == RUN) &&
                         ((r_state == IDLE) || (r_state == SET));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_pre_sec <= '0;
      r_pre_min <= '0;
      r_pre_hr  <= '0;
    end else if (w_load_preset) begin
      r_pre_sec <= r_sec;
      r_pre_min <= r_min;
      r_pre_hr  <= r_hr;
    end
  end

  assign w_pre_sec = r_pre_sec;
  assign w_pre_min = r_pre_min;
  assign w_pre_hr  = r_pre_hr;
`else
  // Without a preset, leaving DONE restores zero, i.e. the time is unchanged.
  assign w_pre_sec = '0;
  assign w_pre_min = '0;
  assign w_pre_hr  = '0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state, edit and countdown logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_field      = r_field;
    w_sec        = r_sec;
    w_min        = r_min;
    w_hr         = r_hr;
    w_alarm_cnt  = r_alarm_cnt;

    if (i_clear) begin
      w_next_state = IDLE;
      w_sec        = '0;
      w_min        = '0;
      w_hr         = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start_stop) begin
            if (w_nonzero) w_next_state = RUN;
          end else if (i_sel) begin
            w_next_state = SET;
          end
        end

        SET: begin
          if (i_start_stop) begin
            w_next_state = w_nonzero ? RUN : IDLE;
          end else if (i_sel) begin
            case (r_field)
              FLD_SEC: w_field = FLD_MIN;
              FLD_MIN: w_field = FLD_HR;
              default: w_next_state = IDLE;
            endcase
          end else if (i_inc) begin
            case (r_field)
              FLD_SEC: w_sec = SEC_W'(inc_wrap(HR_W'(r_sec), HR_W'(SEC_MAX)));
              FLD_MIN: w_min = MIN_W'(inc_wrap(HR_W'(r_min), HR_W'(MIN_MAX)));
              FLD_HR:  w_hr  = inc_wrap(r_hr, HR_MAX);
              default: ;
            endcase
          end
        end

        RUN: begin
          if (i_start_stop) begin
            w_next_state = PAUSE;
          end else if (w_tick) begin
            if (r_sec != '0) begin
              w_sec = r_sec - SEC_W'(1);
            end else begin
              w_sec = SEC_MAX;
              if (r_min != '0) begin
                w_min = r_min - MIN_W'(1);
              end else begin
                w_min = MIN_MAX;
                w_hr  = r_hr - HR_W'(1);
              end
            end
            if (w_last_sec) w_next_state = DONE;
          end
        end

        PAUSE: begin
          if (i_start_stop) w_next_state = RUN;
        end

        DONE: begin
          if (i_start_stop || (w_tick && w_alarm_last)) begin
            w_next_state = IDLE;
            w_sec        = w_pre_sec;
            w_min        = w_pre_min;
            w_hr         = w_pre_hr;
          end else if (w_tick) begin
            w_alarm_cnt = r_alarm_cnt + 8'd1;
          end
        end

        default: w_next_state = IDLE;
      endcase
    end

    // The edit field and alarm count only live inside their own states.
    if (w_next_state != SET)  w_field     = FLD_SEC;
    if (w_next_state != DONE) w_alarm_cnt = '0;
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_field     <= FLD_SEC;
      r_sec       <= '0;
      r_min       <= '0;
      r_hr        <= '0;
      r_alarm_cnt <= '0;
      r_running   <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_field     <= w_field;
      r_sec       <= w_sec;
      r_min       <= w_min;
      r_hr        <= w_hr;
      r_alarm_cnt <= w_alarm_cnt;
      r_running   <= (w_next_state == RUN);
      r_alarm     <= (w_next_state == DONE);
    end
  end

  assign o_seconds = r_sec;
  assign o_minutes = r_min;
  assign o_hours   = r_hr;
  assign o_state   = r_state;
  assign o_field   = r_field;
  assign o_running = r_running;
  assign o_alarm   = r_alarm;

endmodule
